// File: rtl/expr_lane_pipe_pkg.sv
// ---------------------------------------------------------------------------
// expr_lane_pipe_pkg
//
// Shared definitions for the expr_lane_pipe block:
//   op_e    - per-lane 3-bit opcode (ADD, SUB, AND, XRED, LT, SHR, MIN, MAX)
//   OP_W    - width of one lane opcode field
//   COUNT_W - width of the completed-transaction counter
//
// Optional feature macro used by the block: EXPR_LANE_PIPE_SAT_EN
// ---------------------------------------------------------------------------
package expr_lane_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XRED = 3'd3,
    OP_LT   = 3'd4,
    OP_SHR  = 3'd5,
    OP_MIN  = 3'd6,
    OP_MAX  = 3'd7
  } op_e;

  localparam int OP_W    = 3;
  localparam int COUNT_W = 16;

endpackage

// File: rtl/expr_lane_pipe_alu.sv
// ---------------------------------------------------------------------------
// expr_lane_alu
//
// Combinational single-lane ALU. Both operands are extended to W+1 bits
// according to the lane signedness, so every result comes out already
// extended to the output width.
//
// Parameters:
//   W      - operand width (>= 2)
//   SIGNED - 1: operands and result are two's-complement, 0: unsigned
//
// Ports:
//   a   in  [W-1:0]  operand A
//   b   in  [W-1:0]  operand B
//   op  in  [2:0]    opcode (op_e)
//   y   out [W:0]    result, extended per lane signedness
//   sat out          ADD/SUB result was clamped (only with saturation)
//
// Macro EXPR_LANE_PIPE_SAT_EN: when defined, ADD and SUB are clamped to the
// W-bit range of the lane and sat reports the clamp; otherwise ADD/SUB give
// the full W+1-bit result and sat is always 0.
// ---------------------------------------------------------------------------
module expr_lane_alu
  import expr_lane_pipe_pkg::*;
#(
  parameter int W      = 6,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W:0]   y,
  output logic         sat
);

  localparam logic [31:0] W_U = 32'(W);

  logic [W:0]  w_a_ext;
  logic [W:0]  w_b_ext;
  logic [W:0]  w_sum;
  logic [W:0]  w_diff;
  logic [31:0] w_bmod;
  logic [W:0]  w_shr_s;
  logic [W:0]  w_shr_u;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_lt;

  // One extra bit is enough for ADD/SUB to never wrap, which is what makes
  // the full-width result and the overflow test below exact.
  assign w_a_ext = SIGNED ? {a[W-1], a} : {1'b0, a};
  assign w_b_ext = SIGNED ? {b[W-1], b} : {1'b0, b};

  assign w_sum  = w_a_ext + w_b_ext;
  assign w_diff = w_a_ext - w_b_ext;

  // The shift amount treats b as a plain bit pattern, reduced modulo W.
  assign w_bmod = 32'(b) % W_U;

  // Kept as separate assigns so the signed shift is evaluated in a purely
  // signed expression context.
  assign w_shr_s = $signed(w_a_ext) >>> w_bmod;
  assign w_shr_u = w_a_ext >> w_bmod;

  assign w_lt_s = $signed(w_a_ext) < $signed(w_b_ext);
  assign w_lt_u = w_a_ext < w_b_ext;
  assign w_lt   = SIGNED ? w_lt_s : w_lt_u;

`ifdef EXPR_LANE_PIPE_SAT_EN
  logic [W:0] w_hi;
  logic [W:0] w_lo;
  logic       w_add_ovf;
  logic       w_sub_ovf;
  logic [W:0] w_add_clamp;
  logic [W:0] w_sub_clamp;

  // W-bit range limits of the lane, already extended to W+1 bits.
  assign w_hi = SIGNED ? {2'b00, {(W-1){1'b1}}} : {1'b0, {W{1'b1}}};
  assign w_lo = SIGNED ? {2'b11, {(W-1){1'b0}}} : {(W+1){1'b0}};

  // Signed: the W+1-bit result leaves the W-bit range when its top two bits
  // differ. Unsigned: bit W is the carry (ADD) or borrow (SUB).
  assign w_add_ovf = SIGNED ? (w_sum[W] ^ w_sum[W-1]) : w_sum[W];
  assign w_sub_ovf = SIGNED ? (w_diff[W] ^ w_diff[W-1]) : w_diff[W];

  // Unsigned ADD can only overflow upward and unsigned SUB only downward;
  // for signed lanes bit W carries the true sign of the result.
  assign w_add_clamp = (SIGNED && w_sum[W]) ? w_lo : w_hi;
  assign w_sub_clamp = (!SIGNED || w_diff[W]) ? w_lo : w_hi;
`endif

  // Result select per opcode.
  always_comb begin
    y   = '0;
    sat = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        y = w_sum;
`ifdef EXPR_LANE_PIPE_SAT_EN
        if (w_add_ovf) begin
          y   = w_add_clamp;
          sat = 1'b1;
        end
`endif
      end
      OP_SUB: begin
        y = w_diff;
`ifdef EXPR_LANE_PIPE_SAT_EN
        if (w_sub_ovf) begin
          y   = w_sub_clamp;
          sat = 1'b1;
        end
`endif
      end
      OP_AND:  y = w_a_ext & w_b_ext;
      OP_XRED: y = {{W{1'b0}}, ^{a, b}};
      OP_LT:   y = {{W{1'b0}}, w_lt};
      OP_SHR:  y = SIGNED ? w_shr_s : w_shr_u;
      OP_MIN:  y = w_lt ? w_a_ext : w_b_ext;
      OP_MAX:  y = w_lt ? w_b_ext : w_a_ext;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/expr_lane_pipe.sv
// ---------------------------------------------------------------------------
// expr_lane_pipe
//
// Multi-lane expression evaluator with a two-stage elastic pipeline.
// Stage 1 holds the accepted operands/opcodes, stage 2 holds the lane ALU
// results. One transaction per cycle is sustained; out_y/out_sat/out_count
// hold while the consumer stalls.
//
// Parameters:
//   W           - operand width per lane (>= 2)
//   LANES       - number of lanes
//   SIGNED_MASK - bit i set: lane i is two's-complement
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   transaction offered
//   in_ready   out  transaction accepted when in_valid && in_ready
//   in_a       in   [W*LANES]      operand A, lane i at [i*W +: W]
//   in_b       in   [W*LANES]      operand B, same packing
//   in_op      in   [3*LANES]      lane opcode, lane i at [i*3 +: 3]
//   out_valid  out  result available
//   out_ready  in   consumer accepts when out_valid && out_ready
//   out_y      out  [(W+1)*LANES]  lane i result at [i*(W+1) +: W+1]
//   out_sat    out  [LANES]        per-lane saturation flag
//   out_count  out  [16]           completed output transactions (wraps)
//
// Macro EXPR_LANE_PIPE_SAT_EN: enables ADD/SUB saturation in the lane ALUs.
// Without it out_sat is constant 0.
// ---------------------------------------------------------------------------
module expr_lane_pipe
  import expr_lane_pipe_pkg::*;
#(
  parameter int               W           = 6,
  parameter int               LANES       = 4,
  parameter logic [LANES-1:0] SIGNED_MASK = 4'b1010
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W*LANES-1:0]       in_a,
  input  logic [W*LANES-1:0]       in_b,
  input  logic [OP_W*LANES-1:0]    in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(W+1)*LANES-1:0]   out_y,
  output logic [LANES-1:0]         out_sat,
  output logic [COUNT_W-1:0]       out_count
);

  localparam int YW = (W + 1) * LANES;

  logic                    r_s1_valid;
  logic [W*LANES-1:0]      r_s1_a;
  logic [W*LANES-1:0]      r_s1_b;
  logic [OP_W*LANES-1:0]   r_s1_op;

  logic                    r_s2_valid;
  logic [YW-1:0]           r_s2_y;
  logic [LANES-1:0]        r_s2_sat;

  logic [COUNT_W-1:0]      r_count;

  logic                    w_s2_load;
  logic                    w_s1_load;
  logic                    w_emit;
  logic [YW-1:0]           w_alu_y;
  logic [LANES-1:0]        w_alu_sat;

  // Stage 2 can take a new entry if it is empty or being drained this cycle.
  // Stage 1 can take a new entry if it is empty or moving into stage 2, which
  // makes in_ready combinational from out_ready and gives full throughput
  // with only two registers of buffering.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_emit    = r_s2_valid && out_ready;

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_y     = r_s2_y;
  assign out_sat   = r_s2_sat;
  assign out_count = r_count;

  // One ALU per lane, signedness fixed at elaboration from SIGNED_MASK.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    expr_lane_alu #(
      .W      (W),
      .SIGNED (SIGNED_MASK[gi])
    ) u_alu (
      .a   (r_s1_a[gi*W +: W]),
      .b   (r_s1_b[gi*W +: W]),
      .op  (r_s1_op[gi*OP_W +: OP_W]),
      .y   (w_alu_y[gi*(W+1) +: W+1]),
      .sat (w_alu_sat[gi])
    );
  end

  // Stage 1: operand/opcode register. The valid bit follows in_valid whenever
  // the stage is allowed to load; data only moves on a real accept so idle
  // cycles do not disturb the held operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_op <= in_op;
      end
    end
  end

  // Stage 2: result register. While stalled (valid and out_ready low) nothing
  // loads, so the visible result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_sat   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_y   <= w_alu_y;
        r_s2_sat <= w_alu_sat;
      end
    end
  end

  // Completed-transaction counter; wraps silently at the top of its range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_emit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
